// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter that shares one registered XOR unit among NUM_REQ requesters.
// One operation in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module xor_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         xu_in1,
    output logic [WIDTH-1:0]         xu_in2,
    input  logic [WIDTH-1:0]         xu_out1,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic [15:0]              op_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] xu_in1_q, xu_in1_d;
    logic [WIDTH-1:0] xu_in2_q, xu_in2_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  idx;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    // Next-state and datapath updates; everything holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        xu_in1_d    = xu_in1_q;
        xu_in2_d    = xu_in2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        op_count_d  = op_count_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d  = pick_id;
                    xu_in1_d = req_a[32'(pick_id)*WIDTH +: WIDTH];
                    xu_in2_d = req_b[32'(pick_id)*WIDTH +: WIDTH];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                rr_ptr_d = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                // Unit result is valid this cycle; rsp_ready is irrelevant until RESP.
                rsp_data_d  = xu_out1;
                rsp_id_d    = grant_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Accept pulse is asserted only during ISSUE, one-hot on the granted requester.
    always_comb begin
        req_ready = '0;
        if (state_q == StIssue) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // State register with synchronous reset; reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            xu_in1_q    <= '0;
            xu_in2_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            xu_in1_q    <= xu_in1_d;
            xu_in2_q    <= xu_in2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign xu_in1    = xu_in1_q;
    assign xu_in2    = xu_in2_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule
